// File: rtl/systolic_pe_if.sv
// Operand, weight-preload and result signals of one systolic PE.
// master drives operands and weights; slave is the PE itself.
interface systolic_pe_if #(
  parameter int DATA_W = 16
);
  logic              en;
  logic              valid_in;
  logic [DATA_W-1:0] iact_in;
  logic [DATA_W-1:0] psum_in;
  logic              w_load;
  logic [DATA_W-1:0] weight;
  logic              valid_out;
  logic [DATA_W-1:0] iact_out;
  logic [DATA_W-1:0] psum_out;
  logic [DATA_W-1:0] weight_out;
  logic              ovf;

  modport master (
    output en, valid_in, iact_in, psum_in, w_load, weight,
    input  valid_out, iact_out, psum_out, weight_out, ovf
  );

  modport slave (
    input  en, valid_in, iact_in, psum_in, w_load, weight,
    output valid_out, iact_out, psum_out, weight_out, ovf
  );
endinterface

// File: rtl/systolic_pe.sv
// Weight-stationary MAC cell: psum_out <= psum_in + iact_in * w_q, one registered hop.
// Latency 1 cycle; en=0 stalls the datapath (weight loads regardless).
module systolic_pe #(
  parameter int DATA_W   = 16,
  parameter bit SATURATE = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  systolic_pe_if.slave pe
);
  localparam int PW = 2 * DATA_W;
  localparam int SW = 2 * DATA_W + 1;

  logic [DATA_W-1:0] w_q;
  logic [DATA_W-1:0] iact_q;
  logic [DATA_W-1:0] psum_q;
  logic              vld_q;
  logic              ovf_q;

  logic [PW-1:0]     iact_x;
  logic [PW-1:0]     w_x;
  logic [PW-1:0]     product;
  logic [SW-1:0]     sum;
  logic [DATA_W+1:0] sum_top;
  logic              oor;
  logic [DATA_W-1:0] psum_d;
  logic              ovf_d;

  always_comb begin
    iact_x  = {{DATA_W{pe.iact_in[DATA_W-1]}}, pe.iact_in};
    w_x     = {{DATA_W{w_q[DATA_W-1]}}, w_q};
    // Low PW bits of the sign-extended product are exact: the full product fits in PW bits.
    product = iact_x * w_x;
    sum     = {{(DATA_W+1){pe.psum_in[DATA_W-1]}}, pe.psum_in} + {product[PW-1], product};
    // In range only when every bit from the sign down to bit DATA_W-1 agrees.
    sum_top = sum[SW-1:DATA_W-1];
    oor     = !((&sum_top) || !(|sum_top));
    psum_d  = sum[DATA_W-1:0];
    if (SATURATE && oor) begin
      psum_d = sum[SW-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    end
    ovf_d = ovf_q | (pe.en & pe.valid_in & oor);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_q <= '0;
    end else if (pe.w_load) begin
      w_q <= pe.weight;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iact_q <= '0;
      psum_q <= '0;
      vld_q  <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (pe.en) begin
      iact_q <= pe.iact_in;
      psum_q <= psum_d;
      vld_q  <= pe.valid_in;
      ovf_q  <= ovf_d;
    end
  end

  assign pe.valid_out  = vld_q;
  assign pe.iact_out   = iact_q;
  assign pe.psum_out   = psum_q;
  assign pe.weight_out = w_q;
  assign pe.ovf        = ovf_q;
endmodule

// File: tb/tb_systolic_pe.sv
// Drives a saturating and a wrapping PE with identical stimulus; an integer
// reference model queues expected outputs that a monitor compares each cycle.
module tb_systolic_pe;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        en, vld, wl;
  logic [15:0] ia, ps, wv;

  systolic_pe_if #(.DATA_W(16)) if_s ();
  systolic_pe_if #(.DATA_W(16)) if_w ();

  assign if_s.en = en;  assign if_s.valid_in = vld; assign if_s.iact_in = ia;
  assign if_s.psum_in = ps; assign if_s.w_load = wl; assign if_s.weight = wv;
  assign if_w.en = en;  assign if_w.valid_in = vld; assign if_w.iact_in = ia;
  assign if_w.psum_in = ps; assign if_w.w_load = wl; assign if_w.weight = wv;

  systolic_pe #(.DATA_W(16), .SATURATE(1'b1)) dut_s (.clk(clk), .rst_n(rst_n), .pe(if_s));
  systolic_pe #(.DATA_W(16), .SATURATE(1'b0)) dut_w (.clk(clk), .rst_n(rst_n), .pe(if_w));

  typedef struct {
    logic        vld;
    logic [15:0] iact;
    logic [15:0] psum_s;
    logic [15:0] psum_w;
    logic [15:0] wt;
    logic        ovf_s;
    logic        ovf_w;
  } exp_t;

  exp_t q[$];
  exp_t m;
  int   m_w;
  int   passed = 0;
  int   total  = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Plain integer arithmetic: exact sum, then clamp or keep low 16 bits.
  function automatic void mac(input int a, input int p, input int w,
                              output int r_s, output int r_w, output bit o);
    int s;
    s   = p + a * w;
    o   = (s > 32767) || (s < -32768);
    r_w = s & 'hFFFF;
    r_s = (s > 32767) ? 32767 : (s < -32768) ? ('h8000) : (s & 'hFFFF);
  endfunction

  task automatic model_reset();
    m.vld = 1'b0; m.iact = '0; m.psum_s = '0; m.psum_w = '0;
    m.wt = '0; m.ovf_s = 1'b0; m.ovf_w = 1'b0;
    m_w = 0;
  endtask

  task automatic step(input bit e, input bit v, input int a, input int p,
                      input bit l, input int w);
    int r_s, r_w;
    bit o;
    @(negedge clk);
    en = e; vld = v; ia = 16'(a); ps = 16'(p); wl = l; wv = 16'(w);
    if (e) begin
      mac(int'($signed(ia)), int'($signed(ps)), m_w, r_s, r_w, o);
      m.vld    = v;
      m.iact   = ia;
      m.psum_s = 16'(r_s);
      m.psum_w = 16'(r_w);
      if (v && o) begin
        m.ovf_s = 1'b1;
        m.ovf_w = 1'b1;
      end
    end
    if (l) begin
      m_w  = int'($signed(wv));
      m.wt = wv;
    end
    q.push_back(m);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_iact_s"}, int'(if_s.iact_out), 0);
    chk({tag, "_psum_s"}, int'(if_s.psum_out), 0);
    chk({tag, "_wt_s"},   int'(if_s.weight_out), 0);
    chk({tag, "_vld_s"},  int'(if_s.valid_out), 0);
    chk({tag, "_ovf_s"},  int'(if_s.ovf), 0);
    chk({tag, "_psum_w"}, int'(if_w.psum_out), 0);
    chk({tag, "_wt_w"},   int'(if_w.weight_out), 0);
    chk({tag, "_ovf_w"},  int'(if_w.ovf), 0);
  endtask

  // Monitor: pops one expectation per clock edge it was queued for.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("valid_out", int'(if_s.valid_out), int'(e.vld));
        chk("iact_out",  int'(if_s.iact_out),  int'(e.iact));
        chk("psum_sat",  int'(if_s.psum_out),  int'(e.psum_s));
        chk("psum_wrap", int'(if_w.psum_out),  int'(e.psum_w));
        chk("weight_out", int'(if_s.weight_out), int'(e.wt));
        chk("weight_out_w", int'(if_w.weight_out), int'(e.wt));
        chk("ovf_sat",   int'(if_s.ovf), int'(e.ovf_s));
        chk("ovf_wrap",  int'(if_w.ovf), int'(e.ovf_w));
        chk("valid_out_w", int'(if_w.valid_out), int'(e.vld));
        chk("iact_out_w",  int'(if_w.iact_out),  int'(e.iact));
      end
    end
  end

  initial begin
    int a, p, w;
    rst_n = 1'b0;
    en = 1'b0; vld = 1'b0; wl = 1'b0; ia = '0; ps = '0; wv = '0;
    model_reset();
    #12;
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Positive weight
    step(1, 0, 0, 0, 1, 1);
    step(1, 1, 10, 5, 0, 0);
    // Negative weight, then accumulation chain
    step(1, 0, 0, 0, 1, -1);
    step(1, 1, 20, 30, 0, 0);
    step(1, 1, -10, 100, 0, 0);
    step(1, 0, 0, 0, 1, 1);
    step(1, 1, 3, 110, 0, 0);
    // Zero weight
    step(1, 0, 0, 0, 1, 0);
    step(1, 1, 100, 500, 0, 0);
    // Bounds
    step(1, 0, 0, 0, 1, 1);
    step(1, 1, 32767, 0, 0, 0);
    step(1, 0, 0, 0, 1, -1);
    step(1, 1, -32768, 0, 0, 0);
    // Same-cycle load uses old weight; stall holds outputs; load during stall
    step(1, 0, 0, 0, 1, 1);
    step(1, 1, 4, 0, 1, 2);
    step(1, 1, 4, 0, 0, 0);
    step(0, 1, 999, 999, 0, 0);
    step(0, 0, -7, 12, 0, 0);
    step(0, 1, 5, 5, 1, 3);
    step(1, 1, 5, 1, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      a = $urandom_range(0, 1) ? int'($urandom_range(0, 40)) - 20 : int'($urandom_range(0, 65535)) - 32768;
      p = $urandom_range(0, 1) ? int'($urandom_range(0, 400)) - 200 : int'($urandom_range(0, 65535)) - 32768;
      w = $urandom_range(0, 1) ? int'($urandom_range(0, 4)) - 2 : int'($urandom_range(0, 65535)) - 32768;
      step($urandom_range(0, 9) != 0, $urandom_range(0, 1) == 1, a, p,
           $urandom_range(0, 6) == 0, w);
    end

    // Asynchronous reset between edges with an operand in flight
    @(negedge clk);
    en = 1'b1; vld = 1'b1; ia = 16'd55; ps = 16'd66; wl = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("async");
    model_reset();
    @(posedge clk);
    #1;
    chk_zero("held");
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 1, 7, 123, 0, 0);
    step(1, 1, -5, -9, 0, 0);

    // Drain with a bounded wait
    for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
    #2;
    chk("drain_queue", q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/systolic_pe.md
# systolic_pe

Weight-stationary multiply-accumulate processing element, the unit cell of the NPU systolic array. Each PE holds one signed weight. It forwards activations horizontally and accumulates partial sums vertically: psum_out = psum_in + iact_in × weight. Outputs are registered, so a grid of PEs forms a one-cycle-per-hop pipeline.

## Interface
- DATA_W, 16: width of activations, weights and partial sums (two's complement).
- SATURATE, 1: 1 = clamp psum_out to the DATA_W signed range; 0 = wrap modulo 2^DATA_W.

- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  clock enable for the datapath; 0 holds all datapath outputs.
- valid_in  input  1  iact_in/psum_in carry a valid operand pair.
- iact_in  input  DATA_W  signed input activation from the west neighbour.
- psum_in  input  DATA_W  signed partial sum from the north neighbour.
- w_load  input  1  load weight into the stationary weight register.
- weight  input  DATA_W  signed weight value to load.
- valid_out  output  1  registered valid_in.
- iact_out  output  DATA_W  iact_in delayed by one cycle, to the east neighbour.
- psum_out  output  DATA_W  registered MAC result, to the south neighbour.
- weight_out  output  DATA_W  current weight register, for daisy-chained preload.
- ovf  output  1  sticky flag set on any saturation or wrap event.

## Operation
- Weight register w_reg: on w_load=1, w_reg ← weight. Independent of en. weight_out = w_reg.
- MAC: product = iact_in × w_reg, full 2·DATA_W signed. sum = sign-extend(psum_in) + product, at 2·DATA_W+1 bits. No intermediate truncation.
- Result with SATURATE=1: sum > 2^(DATA_W-1)-1 gives 32767; sum < -2^(DATA_W-1) gives -32768; otherwise sum[DATA_W-1:0].
- Result with SATURATE=0: sum[DATA_W-1:0].
- ovf is set to 1 when en=1, valid_in=1 and sum is outside the DATA_W range. It stays 1 until reset.
- When en=1: iact_out ← iact_in, psum_out ← result, valid_out ← valid_in. This update happens regardless of valid_in. valid_out only qualifies the data.
- When en=0: iact_out, psum_out and valid_out hold. ovf is not updated.
- Weight values 0, +1 and -1 need no special case. They fall out of the general multiply as pass-through, add and subtract.

## Timing
- Reset (rst_n=0, asynchronous): iact_out, psum_out, weight_out (w_reg), valid_out and ovf all become 0 immediately. They stay 0 while reset is held.
- Reset deassertion is synchronised externally. The first capture occurs on the first rising edge with rst_n=1.
- Latency: 1 cycle from iact_in/psum_in to iact_out/psum_out/valid_out. Throughput is 1 operand pair per cycle.
- Weight load takes effect on the edge after w_load. A MAC in the same cycle as w_load uses the old w_reg.
- A load-then-compute sequence needs w_load one cycle before the first valid operand.
- Simultaneous w_load and en=0: the weight still loads.
- Reset mid-stream discards all in-flight data. w_reg returns to 0, so psum_out = psum_in until the weight is reloaded.
- No combinational path from any input to any output.

## Test plan
- Positive weight: load weight=1; then iact_in=10, psum_in=5, en=1, valid_in=1. Next cycle: psum_out=15, iact_out=10, valid_out=1.
- Negative and zero weight: weight=-1 with iact=20, psum=30 gives psum_out=10. weight=-1 with iact=-10, psum=100 gives 110. weight=0 with iact=100, psum=500 gives 500.
- Accumulation chain: after the 110 result, load weight=1 and feed psum_in=psum_out(110), iact=3. Result psum_out=113.
- Bounds with SATURATE=1: weight=1, iact=32767, psum=0 gives 32767 with ovf=0. weight=-1, iact=-32768, psum=0 gives 32767 with ovf=1. Repeat with SATURATE=0: -32768 with ovf=1.
- Load timing and stall: assert w_load(weight=2) in the same cycle as iact=4, psum=0 while the old weight is 1. Result is 4; the next operand uses 2. With en=0, outputs hold for 3 cycles.
- Async reset: assert rst_n=0 between clock edges mid-stream. All outputs become 0 immediately with no clock edge. After release, weight_out=0 and psum_out=psum_in.
